spi_flash_ctrl: RTL and testbench
=================================

Name: spi_flash_ctrl

Overview:
Byte-wide SPI master that sequences the configuration-flash pins (SCK, MOSI, MISO, CS) for the j1 core. It replaces bit-banged flash access through misc.out/misc.in.
- Sits behind the registered IO strobes (io_wr_, io_rd_, io_addr_, dout_) in top.
- The top-level decode turns those strobes into the single-cycle data_wr, ctrl_wr and data_rd pulses.
- Firmware writes a byte, polls busy, then reads the received byte.

Parameters:
CLKDIV, 2, SCK half-period in clk cycles (legal range 1..255)
BITS, 8, bits per transfer (fixed at 8; kept for the package width constant)

Ports:
clk  in  1  system clock (PLL output)
reset  in  1  asynchronous, active-high reset
data_wr  in  1  single-cycle strobe: start a transfer of tx_data
ctrl_wr  in  1  single-cycle strobe: load the CS/control register from tx_data[1:0]
data_rd  in  1  single-cycle strobe: firmware read of rx_data
tx_data  in  8  write data (dout_[7:0])
rx_data  out  8  last received byte
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when a byte completes
sck  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  1  flash chip select, active low

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, sck=0, mosi=0, cs_n=1, busy=0, done=0.
  - rx_data=8'h00, divider=0, bit counter=0, pending CS=none, autoread mode=0.
  - Reset mid-transfer aborts immediately. No partial byte reaches rx_data.
- Mode 0, MSB first: SCK idles low, MISO is sampled on the rising edge, MOSI changes on the falling edge.
- States: IDLE, LO, HI.
- IDLE + data_wr:
  - tx_shift<=tx_data, mosi<=tx_data[7], bit=0, div=0.
  - busy<=1 on the next edge; enter LO.
- LO: div counts 0..CLKDIV-1. At terminal count: sck<=1, rx_shift<={rx_shift[6:0],miso}, div=0, enter HI.
- HI, at terminal count:
  - sck<=0, div=0.
  - If bit==7: rx_data<=rx_shift, done<=1 for one cycle, busy<=0, enter IDLE.
  - Otherwise: tx_shift<<=1, mosi<=new tx_shift[7], bit++, enter LO.
- Timing:
  - busy stays high for exactly 16*CLKDIV cycles.
  - done asserts in the same cycle busy falls.
  - A back-to-back data_wr is accepted in the cycle after busy falls.
- data_wr while busy: ignored; no queueing. Firmware must poll busy.
- ctrl_wr in IDLE: cs_n<=~tx_data[0] and autoread<=tx_data[1], applied the next cycle.
- ctrl_wr while busy:
  - Value is latched as pending and applied in the cycle the byte completes (CS never toggles mid-byte).
  - A second ctrl_wr while busy overwrites the pending value.
- Simultaneous data_wr and ctrl_wr in IDLE: control applies first (cs_n updates that edge); the transfer starts the same edge.
- data_rd has no effect on state unless SPI_FLASH_AUTOREAD_EN is defined.
- cs_n is purely firmware-controlled; the block never asserts it on its own.

Optional Feature:
SPI_FLASH_AUTOREAD_EN
- Defined:
  - When autoread=1, IDLE and data_rd: start a transfer with tx byte 8'hFF, same as a data_wr.
  - Firmware streams flash by read-poll-read with no dummy write.
  - data_rd while busy is ignored.
- Undefined:
  - autoread bit is written but ignored and reads as 0.
  - data_rd is unused; no extra logic.

Decomposition:
- Package spi_flash_pkg holds:
  - state encoding (IDLE=2'd0, LO=2'd1, HI=2'd2);
  - BITS constant;
  - control bit indices (CTRL_CS=0, CTRL_AUTO=1);
  - flash command constants (CMD_READ=8'h03, CMD_JEDEC=8'h9F, CMD_WAKE=8'hAB, DUMMY=8'hFF).
- One natural sub-module: spi_tick_div. It holds the CLKDIV half-period counter with a clear input and emits a terminal-count tick.
- The shifter and FSM stay in spi_flash_ctrl.

Test Plan:
- Reset then idle → cs_n=1, sck=0, busy=0, rx_data=00. A reset asserted mid-byte (cycle 10) returns all outputs to these values.
- CLKDIV=2; ctrl_wr 8'h01, then data_wr 8'hA5; slave model drives 8'h3C → MOSI bits 1,0,1,0,0,1,0,1 on rising edges. busy high for 32 cycles, done pulses once, rx_data=8'h3C, cs_n=0 throughout.
- data_wr 8'h9F, then data_wr 8'h00 at cycle 5 → second write ignored. Exactly 8 SCK rising edges; received byte matches the model's first byte.
- ctrl_wr 8'h00 at cycle 12 of a transfer → cs_n stays 0 until the done cycle, then goes 1 the same edge busy falls.
- Simultaneous ctrl_wr 8'h01 and data_wr 8'h03 from IDLE → cs_n falls the same edge busy rises; first SCK rise occurs CLKDIV cycles later.
- With SPI_FLASH_AUTOREAD_EN and autoread=1, data_rd in IDLE → transfer starts with MOSI all ones. Slave returns 8'h5A, then rx_data=8'h5A. Without the macro, the same stimulus leaves busy=0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared types and constants for the SPI flash master
package spi_flash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  localparam int BITS      = 8;
  localparam int CTRL_CS   = 0;
  localparam int CTRL_AUTO = 1;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;
  localparam logic [7:0] CMD_WAKE  = 8'hAB;
  localparam logic [7:0] DUMMY     = 8'hFF;

endpackage

// File: rtl/spi_tick_div.sv
// rtl/spi_tick_div.sv - SCK half-period counter, ticks on its terminal count
module spi_tick_div #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [7:0] div_q, div_d;

  assign tick = (div_q == 8'(CLKDIV - 1));

  always_comb begin
    div_d = div_q + 8'd1;
    if (clear || tick) div_d = 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= 8'd0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/spi_flash_ctrl.sv
// rtl/spi_flash_ctrl.sv - byte-wide mode-0 SPI master for the config flash
// Optional: SPI_FLASH_AUTOREAD_EN lets data_rd start a dummy-byte transfer.
module spi_flash_ctrl
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLKDIV = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_wr,
  input  logic            ctrl_wr,
  input  logic            data_rd,
  input  logic [BITS-1:0] tx_data,
  output logic [BITS-1:0] rx_data,
  output logic            busy,
  output logic            done,
  output logic            sck,
  output logic            mosi,
  input  logic            miso,
  output logic            cs_n
);

  state_e          state_q, state_d;
  logic [BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [2:0]      bit_q, bit_d;
  logic            sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            pend_valid_q, pend_valid_d;
  logic [1:0]      pend_q, pend_d, ctrl_val;
  logic            ctrl_apply, finish, tick, start;
  logic [BITS-1:0] start_byte;

  spi_tick_div #(.CLKDIV(CLKDIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

`ifdef SPI_FLASH_AUTOREAD_EN
  logic auto_q, auto_d;
  assign start      = data_wr || (data_rd && auto_q);
  assign start_byte = data_wr ? tx_data : DUMMY;
`else
  logic unused_bits;
  assign start       = data_wr;
  assign start_byte  = tx_data;
  assign unused_bits = ^{data_rd, ctrl_val[CTRL_AUTO]};
`endif

  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    bit_d        = bit_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    ctrl_apply   = 1'b0;
    ctrl_val     = pend_q;
    finish       = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        tx_shift_d = start_byte;
        mosi_d     = start_byte[BITS-1];
        bit_d      = 3'd0;
        busy_d     = 1'b1;
        state_d    = LO;
      end
      LO: if (tick) begin
        sck_d      = 1'b1;
        rx_shift_d = {rx_shift_q[BITS-2:0], miso};
        state_d    = HI;
      end
      HI: if (tick) begin
        sck_d = 1'b0;
        if (bit_q == 3'(BITS - 1)) begin
          finish    = 1'b1;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          tx_shift_d = {tx_shift_q[BITS-2:0], 1'b0};
          mosi_d     = tx_shift_q[BITS-2];
          bit_d      = bit_q + 3'd1;
          state_d    = LO;
        end
      end
      default: state_d = IDLE;
    endcase

    // Control writes during a byte are held back so CS only moves on a byte boundary.
    if (state_q == IDLE) begin
      ctrl_apply = ctrl_wr;
      ctrl_val   = tx_data[1:0];
    end else begin
      if (ctrl_wr) begin
        pend_valid_d = 1'b1;
        pend_d       = tx_data[1:0];
      end
      if (finish && (ctrl_wr || pend_valid_q)) begin
        ctrl_apply   = 1'b1;
        ctrl_val     = ctrl_wr ? tx_data[1:0] : pend_q;
        pend_valid_d = 1'b0;
      end
    end

    cs_n_d = cs_n_q;
    if (ctrl_apply) cs_n_d = ~ctrl_val[CTRL_CS];
`ifdef SPI_FLASH_AUTOREAD_EN
    auto_d = auto_q;
    if (ctrl_apply) auto_d = ctrl_val[CTRL_AUTO];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      bit_q        <= 3'd0;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= 2'd0;
`ifdef SPI_FLASH_AUTOREAD_EN
      auto_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      bit_q        <= bit_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
`ifdef SPI_FLASH_AUTOREAD_EN
      auto_q       <= auto_d;
`endif
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb/tb_spi_flash_ctrl.sv - self-checking bench for spi_flash_ctrl (mode-0 slave model + rx scoreboard)
module tb_spi_flash_ctrl;
  import spi_flash_pkg::*;

  localparam int CLKDIV = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_wr = 1'b0, ctrl_wr = 1'b0, data_rd = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, sck, mosi, miso, cs_n;

  spi_flash_ctrl #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .reset(reset), .data_wr(data_wr), .ctrl_wr(ctrl_wr), .data_rd(data_rd),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] sb_q[$];

  logic [7:0] slave_reg = 8'h00;
  logic [2:0] slave_idx = 3'd0;
  logic [7:0] mosi_cap = 8'h00;
  int sck_rises = 0, busy_cnt = 0, done_cnt = 0, cs_bad = 0;
  logic exp_cs_r = 1'b1, cs_at_done = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mode-0 slave: presents the current bit before the first rise, advances on each fall.
  assign miso = slave_reg[3'd7 - slave_idx];
  always @(negedge sck) slave_idx = slave_idx + 3'd1;

  always @(posedge sck) begin
    mosi_cap = {mosi_cap[6:0], mosi};
    sck_rises++;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        busy_cnt++;
        if (cs_n !== exp_cs_r) cs_bad++;
      end
      if (done) begin
        done_cnt++;
        cs_at_done = cs_n;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_done: got rx %0h with empty scoreboard", rx_data);
        end else begin
          check("sb_rx", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ctrl(input logic [7:0] v);
    ctrl_wr = 1'b1;
    tx_data = v;
    cycle();
    ctrl_wr = 1'b0;
    check("ctrl_cs_n", {31'd0, cs_n}, {31'd0, ~v[0]});
  endtask

  task automatic do_xfer(input string tag, input logic [7:0] txb, input logic [7:0] slv,
                         input logic [7:0] exp_rx, input logic [7:0] exp_mosi,
                         input logic exp_cs, input logic exp_cs_after,
                         input int inj_cyc, input int inj_kind,
                         input bit with_ctrl, input bit use_rd);
    int n, first_rise;
    slave_reg = slv; slave_idx = 3'd0; mosi_cap = 8'h00;
    sck_rises = 0; busy_cnt = 0; done_cnt = 0; cs_bad = 0;
    exp_cs_r = exp_cs; cs_at_done = 1'bx; first_rise = -1;
    sb_q.push_back(exp_rx);
    tx_data = txb;
    if (use_rd) data_rd = 1'b1; else data_wr = 1'b1;
    if (with_ctrl) ctrl_wr = 1'b1;
    cycle();
    data_wr = 1'b0; data_rd = 1'b0; ctrl_wr = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 200) begin
      if (n == inj_cyc) begin
        tx_data = 8'h00;
        if (inj_kind == 1) data_wr = 1'b1; else ctrl_wr = 1'b1;
      end
      cycle();
      data_wr = 1'b0; ctrl_wr = 1'b0;
      n++;
      if (sck && first_rise < 0) first_rise = n;
    end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    cycle();
    check({tag, "_busy_cycles"}, busy_cnt, 16 * CLKDIV);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_sck_rises"}, sck_rises, 8);
    check({tag, "_mosi"}, {24'd0, mosi_cap}, {24'd0, exp_mosi});
    check({tag, "_cs_mid_byte"}, cs_bad, 0);
    check({tag, "_cs_at_done"}, {31'd0, cs_at_done}, {31'd0, exp_cs_after});
    check({tag, "_first_rise"}, first_rise, CLKDIV);
  endtask

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_rx;
    logic       exp_cs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{8'h01, 8'hA5,     8'h3C, 8'h3C, 1'b0};
    vecs[1] = '{8'h01, CMD_JEDEC, 8'hC2, 8'hC2, 1'b0};
    vecs[2] = '{8'h00, CMD_READ,  DUMMY, 8'hFF, 1'b1};
    vecs[3] = '{8'h01, CMD_WAKE,  8'h81, 8'h81, 1'b0};

    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_rx", {24'd0, rx_data}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      write_ctrl(vecs[i].ctrl);
      do_xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].slv, vecs[i].exp_rx, vecs[i].tx,
              vecs[i].exp_cs, vecs[i].exp_cs, -1, 0, 1'b0, 1'b0);
    end

    write_ctrl(8'h01);
    do_xfer("ignored_wr", CMD_JEDEC, 8'h5A, 8'h5A, CMD_JEDEC, 1'b0, 1'b0, 5, 1, 1'b0, 1'b0);

    do_xfer("late_ctrl", 8'h66, 8'h99, 8'h99, 8'h66, 1'b0, 1'b1, 12, 2, 1'b0, 1'b0);
    check("late_ctrl_cs_after", {31'd0, cs_n}, 32'd1);

    do_xfer("simul", CMD_READ, 8'hE7, 8'hE7, CMD_READ, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0);

    write_ctrl(8'h03);
`ifdef SPI_FLASH_AUTOREAD_EN
    do_xfer("autoread", 8'h00, 8'h5A, 8'h5A, 8'hFF, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);
    check("autoread_rx", {24'd0, rx_data}, 32'h5A);
`else
    data_rd = 1'b1;
    cycle();
    data_rd = 1'b0;
    check("noauto_busy0", {31'd0, busy}, 32'd0);
    repeat (4) cycle();
    check("noauto_busy1", {31'd0, busy}, 32'd0);
`endif

    slave_reg = 8'hF0; slave_idx = 3'd0;
    tx_data = 8'hA5;
    data_wr = 1'b1;
    cycle();
    data_wr = 1'b0;
    repeat (10) cycle();
    #2 reset = 1'b1;
    #1;
    check("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    check("midrst_sck", {31'd0, sck}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_mosi", {31'd0, mosi}, 32'd0);
    check("midrst_rx", {24'd0, rx_data}, 32'd0);
    repeat (2) cycle();
    reset = 1'b0;
    slave_idx = 3'd0;
    repeat (40) cycle();
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_rx", {24'd0, rx_data}, 32'd0);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
